// File: rtl/fifo_rd_pkg.sv
// Shared types and width helpers for the async-FIFO read-side arbiter.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } rd_state_e;

  function automatic int id_width(input int num_req);
    return $clog2(num_req);
  endfunction

  function automatic int cnt_width(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

  // Widths for the default 4-consumer, 4-pop configuration
  localparam int ID_W  = id_width(4);
  localparam int CNT_W = cnt_width(4);

endpackage

// File: rtl/fifo_rd_arbiter_rr.sv
// Rotating-priority picker: first requester at or above ptr, wrapping around.
module rr_arbiter
  import fifo_rd_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         onehot,
  output logic [$clog2(NUM_REQ)-1:0] index,
  output logic                       any
);

  localparam int IDW = id_width(NUM_REQ);

  // Scan candidates starting from ptr; the first hit wins
  always_comb begin : pick_p
    logic [IDW-1:0] cand_s;
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    cand_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = IDW'((int'(ptr) + i) % NUM_REQ);
      if (!any && req[cand_s]) begin
        any            = 1'b1;
        index          = cand_s;
        onehot[cand_s] = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Read-side burst scheduler sharing one FIFO read port among NUM_REQ consumers.
// Optional stall watchdog enabled by defining RD_ARB_WATCHDOG_EN.
module fifo_rd_arbiter
  import fifo_rd_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                       rclk,
  input  logic                       rrst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       fifo_empty,
  input  logic [DATA_WIDTH-1:0]      fifo_rdata,
  output logic                       fifo_r_en,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  output logic [$clog2(NUM_REQ)-1:0] out_id,
  output logic                       burst_done,
  output logic                       timeout_err
);

  localparam int IDW = id_width(NUM_REQ);
  localparam int CW  = cnt_width(BURST_LEN);
  localparam logic [CW-1:0]  LAST_CNT = CW'(BURST_LEN - 1);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);

  rd_state_e          state_r;
  rd_state_e          state_s;
  logic [NUM_REQ-1:0] gnt_r;
  logic [NUM_REQ-1:0] pick_onehot_s;
  logic [IDW-1:0]     pick_index_s;
  logic               pick_any_s;
  logic [IDW-1:0]     winner_r;
  logic [IDW-1:0]     ptr_r;
  logic [CW-1:0]      cnt_r;
  logic               req_held_s;
  logic               ren_s;
  logic               pop_s;
  logic               last_pop_s;
  logic               stall_to_s;
  logic               out_valid_r;
  logic [IDW-1:0]     out_id_r;
  logic               burst_done_r;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req    (req),
    .ptr    (ptr_r),
    .onehot (pick_onehot_s),
    .index  (pick_index_s),
    .any    (pick_any_s)
  );

  // gnt_r is only non-zero during BURST, so this is req[winner] while granted
  assign req_held_s = |(gnt_r & req);
  assign pop_s      = ren_s & ~fifo_empty;
  assign last_pop_s = pop_s & (cnt_r == LAST_CNT);

`ifdef RD_ARB_WATCHDOG_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_r;
  logic          timeout_err_r;

  assign stall_to_s = (state_r == BURST) & req_held_s & ~pop_s &
                      (stall_r == SW'(TIMEOUT - 1));

  // Stall counter: cleared outside BURST and on every accepted pop
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      stall_r       <= '0;
      timeout_err_r <= 1'b0;
    end else begin
      timeout_err_r <= stall_to_s;
      if (state_r != BURST || pop_s) begin
        stall_r <= '0;
      end else begin
        stall_r <= stall_r + 1'b1;
      end
    end
  end

  assign timeout_err = timeout_err_r;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^TIMEOUT;
  assign stall_to_s       = 1'b0;
  assign timeout_err      = 1'b0;
`endif

  // State register
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state: a pop that fills the burst wins over a simultaneous req drop
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_any_s && !fifo_empty) begin
          state_s = BURST;
        end else begin
          state_s = IDLE;
        end
      end
      BURST: begin
        if (last_pop_s || !req_held_s || stall_to_s) begin
          state_s = DONE;
        end else begin
          state_s = BURST;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode: read enable follows the granted consumer's request
  always_comb begin
    ren_s = 1'b0;
    case (state_r)
      BURST:   ren_s = req_held_s;
      IDLE:    ren_s = 1'b0;
      DONE:    ren_s = 1'b0;
      default: ren_s = 1'b0;
    endcase
  end

  // Grant, winner, pop count and round-robin pointer
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      gnt_r    <= '0;
      winner_r <= '0;
      ptr_r    <= '0;
      cnt_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (state_s == BURST) begin
            gnt_r    <= pick_onehot_s;
            winner_r <= pick_index_s;
            cnt_r    <= '0;
          end
        end
        BURST: begin
          if (pop_s) begin
            cnt_r <= cnt_r + 1'b1;
          end
          if (state_s == DONE) begin
            gnt_r <= '0;
          end
        end
        DONE: begin
          gnt_r <= '0;
          ptr_r <= (winner_r == LAST_ID) ? '0 : winner_r + 1'b1;
        end
        default: gnt_r <= '0;
      endcase
    end
  end

  // Read data arrives one cycle after the pop; tag it with the pop's owner
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      out_valid_r  <= 1'b0;
      out_id_r     <= '0;
      burst_done_r <= 1'b0;
    end else begin
      out_valid_r  <= pop_s;
      burst_done_r <= (state_r == BURST) && (state_s == DONE);
      if (pop_s) begin
        out_id_r <= winner_r;
      end
    end
  end

  assign fifo_r_en  = ren_s;
  assign gnt        = gnt_r;
  assign out_valid  = out_valid_r;
  assign out_id     = out_id_r;
  assign burst_done = burst_done_r;
  assign out_data   = fifo_rdata;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Self-checking bench for fifo_rd_arbiter: queue-based FIFO plus a behavioural
// scheduler model, directed scenarios with literal pins, then random traffic.
module tb_fifo_rd_arbiter;
  import fifo_rd_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BL = 4;
  localparam int TO = 16;

  logic            rclk = 1'b0;
  logic            rrst_n;
  logic [N-1:0]    req;
  logic            fifo_empty;
  logic [DW-1:0]   fifo_rdata;
  logic            fifo_r_en;
  logic [N-1:0]    gnt;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic [ID_W-1:0] out_id;
  logic            burst_done;
  logic            timeout_err;

  fifo_rd_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .req(req), .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata), .fifo_r_en(fifo_r_en), .gnt(gnt), .out_data(out_data),
    .out_valid(out_valid), .out_id(out_id), .burst_done(burst_done),
    .timeout_err(timeout_err)
  );

  always #5 rclk = ~rclk;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] mq[$];
  logic          hold_empty;
  logic [DW-1:0] rdata_next;

  // model: phase 0 idle, 1 granted, 2 release cycle
  int            m_phase, m_owner, m_ptr, m_pops, m_stall;
  bit            m_to, m_vld;
  int            m_id;
  logic [DW-1:0] m_data;

  int       data_log[$];
  int       id_log[$];
  int       gnt_log[$];
  int       vcyc_log[$];
  int       done_cnt, to_cnt, cyc;
  logic [N-1:0] prev_gnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    fq.push_back(v);
    mq.push_back(v);
  endtask

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_ptr = 0; m_pops = 0; m_stall = 0;
    m_to = 1'b0; m_vld = 1'b0; m_id = 0; m_data = '0;
  endtask

  task automatic clear_logs();
    data_log.delete(); id_log.delete(); gnt_log.delete(); vcyc_log.delete();
    done_cnt = 0; to_cnt = 0; cyc = 0; prev_gnt = '0;
  endtask

  // One clock cycle, entered and left at a falling edge
  task automatic step();
    logic [N-1:0] e_gnt;
    bit           e_ren, pop;
    fifo_empty = (fq.size() == 0) || hold_empty;
    fifo_rdata = rdata_next;
    #1;
    e_gnt = (m_phase == 1) ? N'(1 << m_owner) : '0;
    e_ren = (m_phase == 1) && req[m_owner];
    check("gnt", gnt, e_gnt);
    check("fifo_r_en", fifo_r_en, e_ren);
    check("out_valid", out_valid, m_vld);
    if (m_vld) begin
      check("out_id", out_id, m_id);
      check("out_data", out_data, m_data);
    end
    check("burst_done", burst_done, m_phase == 2);
    check("timeout_err", timeout_err, (m_phase == 2) && m_to);
    if (out_valid) begin
      data_log.push_back(out_data); id_log.push_back(out_id); vcyc_log.push_back(cyc);
    end
    if (gnt != '0 && prev_gnt == '0) begin
      for (int k = 0; k < N; k++) if (gnt[k]) gnt_log.push_back(k);
    end
    prev_gnt = gnt;
    if (burst_done) done_cnt++;
    if (timeout_err) to_cnt++;
    // FIFO emulation responds to the DUT's read enable
    if (fifo_r_en && !fifo_empty && fq.size() > 0) rdata_next = fq.pop_front();
    else rdata_next = DW'($urandom);
    // reference scheduler advances on the same inputs
    pop   = e_ren && !fifo_empty;
    m_vld = pop;
    if (pop) begin
      m_id   = m_owner;
      m_data = (mq.size() > 0) ? mq.pop_front() : '0;
    end
    case (m_phase)
      0: begin
        if (req != '0 && !fifo_empty) begin
          for (int k = N - 1; k >= 0; k--) if (req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
          m_phase = 1; m_pops = 0; m_stall = 0;
        end
      end
      1: begin
        if (pop) m_pops++;
        if (pop && m_pops == BL) m_phase = 2;
        else if (!req[m_owner]) m_phase = 2;
        else begin
`ifdef RD_ARB_WATCHDOG_EN
          if (pop) m_stall = 0;
          else begin
            m_stall++;
            if (m_stall >= TO) begin m_phase = 2; m_to = 1'b1; end
          end
`endif
        end
      end
      default: begin
        m_ptr = (m_owner + 1) % N; m_phase = 0; m_to = 1'b0;
      end
    endcase
    cyc++;
    @(negedge rclk);
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_ren", fifo_r_en, 0);
    check("rst_vld", out_valid, 0);
    check("rst_done", burst_done, 0);
    check("rst_id", out_id, 0);
    model_reset(); fq.delete(); mq.delete(); clear_logs();
    hold_empty = 1'b0; req = '0;
    @(negedge rclk); @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  initial begin
    rrst_n = 1'b0; req = '0; hold_empty = 1'b0; rdata_next = '0;
    fifo_empty = 1'b1; fifo_rdata = '0;
    model_reset(); clear_logs();
    @(negedge rclk);
    do_reset();

    // Single requester, 6 words: burst of 4, bubble, burst of 2 then stall
    for (int i = 0; i < 6; i++) push(DW'(8'h10 + i));
    req = 4'b0001;
    repeat (20) step();
    check("A_count", data_log.size(), 6);
    for (int i = 0; i < 6; i++) check("A_data", data_log[i], 8'h10 + i);
    for (int i = 0; i < 6; i++) check("A_id", id_log[i], 0);
    check("A_b2b", vcyc_log[3] - vcyc_log[0], 3);
    check("A_bubble", vcyc_log[4] - vcyc_log[3], 3);
    check("A_grants", gnt_log.size(), 2);
    check("A_done", done_cnt, 1);
    check("A_stalled_gnt", gnt, 4'b0001);
    req = '0;
    repeat (3) step();

    // Fairness with all consumers requesting and FIFO never empty
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 31; c++) begin
      while (fq.size() < 6) push(DW'($urandom));
      step();
    end
    check("B_grants", gnt_log.size(), 5);
    for (int i = 0; i < 5; i++) check("B_order", gnt_log[i], i % 4);
    check("B_pops", id_log.size(), 20);
    for (int i = 0; i < 20; i++) check("B_id", id_log[i], (i / 4) % 4);

    // Empty stall mid-burst for consumer 2
    do_reset();
    req = 4'b0100;
    push(8'hA0); push(8'hA1);
    repeat (3) step();
    for (int i = 0; i < 5; i++) begin
      step();
      check("C_gap_ren", fifo_r_en, 1);
      check("C_gap_vld", out_valid, 0);
    end
    push(8'hA2); push(8'hA3);
    repeat (6) step();
    check("C_pops", data_log.size(), 4);
    check("C_data3", data_log[3], 8'hA3);
    check("C_grant", gnt_log[0], 2);
    check("C_done", done_cnt, 1);

    // Early release by consumer 1 after one pop
    do_reset();
    for (int i = 0; i < 8; i++) push(DW'(8'h30 + i));
    req = 4'b0010;
    repeat (2) step();
    req = 4'b0101;
    repeat (6) step();
    check("D_first", gnt_log[0], 1);
    check("D_next", gnt_log[1], 2);
    check("D_id0", id_log[0], 1);
    check("D_id1", id_log[1], 2);

    // Asynchronous reset during the third pop
    do_reset();
    for (int i = 0; i < 8; i++) push(DW'(8'h50 + i));
    req = 4'b0010;
    repeat (3) step();
    check("E_pre_vld", out_valid, 1);
    check("E_pre_gnt", gnt, 4'b0010);
    do_reset();
    for (int i = 0; i < 8; i++) push(DW'(8'h60 + i));
    req = 4'b1111;
    repeat (4) step();
    check("E_after", gnt_log[0], 0);

    // Stall with FIFO empty for a long time
    do_reset();
    push(8'h77);
    req = 4'b0001;
    repeat (30) step();
`ifdef RD_ARB_WATCHDOG_EN
    check("F_to", to_cnt, 1);
    check("F_done", done_cnt, 1);
    push(8'h78);
    req = 4'b0011;
    repeat (4) step();
    check("F_ptr", gnt_log[gnt_log.size() - 1], 1);
`else
    check("F_to", to_cnt, 0);
    check("F_done", done_cnt, 0);
    check("F_hold", gnt, 4'b0001);
`endif
    req = '0;
    repeat (3) step();

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(7) == 0) req = N'($urandom);
      if ($urandom_range(1) == 0 && fq.size() < 12) push(DW'($urandom));
      hold_empty = ($urandom_range(9) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
